// File: rtl/dftprobe_tdo_deser_if.sv
// Captured-word handshake bundle for dftprobe_tdo_deser.
// dout_par exists only when DFTTDO_PARITY_EN is defined.
interface dftprobe_tdo_deser_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             ovf;
`ifdef DFTTDO_PARITY_EN
    logic             dout_par;
`endif

    modport master (
        output dout,
        output dout_valid,
        output ovf,
`ifdef DFTTDO_PARITY_EN
        output dout_par,
`endif
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  ovf,
`ifdef DFTTDO_PARITY_EN
        input  dout_par,
`endif
        output dout_ready
    );
endinterface

// File: rtl/dftprobe_tdo_deser.sv
// Scan-out capture probe: packs tdo_encore LSB-first into WIDTH-bit words behind valid/ready.
// Optional registered even parity on dout when DFTTDO_PARITY_EN is defined.
module dftprobe_tdo_deser #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  tdo_encore,
    input  logic                  ten_encore,
    input  logic                  clr,
    dftprobe_tdo_deser_if.master  bus,
    input  logic                  CELG,
    input  logic                  CELSUB,
    input  logic                  CELV
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} mode_e;

    logic [WIDTH-1:0] shreg;
    logic [CntW-1:0]  bcnt;
    logic [WIDTH-1:0] hold;
    logic             hold_valid;
    logic             ovf_flag;
    logic [WIDTH-1:0] cand;
    logic             can_load;
    mode_e            mode;
`ifdef DFTTDO_PARITY_EN
    logic             par;
`endif

    // Mode is implied by the enable pin; there is no separate state register.
    assign mode     = ten_encore ? StShift : StIdle;
    assign cand     = {tdo_encore, shreg[WIDTH-1:1]};
    assign can_load = !hold_valid || bus.dout_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg      <= '0;
            bcnt       <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            ovf_flag   <= 1'b0;
`ifdef DFTTDO_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            if (hold_valid && bus.dout_ready) begin
                hold_valid <= 1'b0;
            end
            if (clr) begin
                ovf_flag <= 1'b0;
            end
            unique case (mode)
                StShift: begin
                    shreg <= cand;
                    if (bcnt == LastBit) begin
                        bcnt <= '0;
                        if (can_load) begin
                            hold       <= cand;
                            hold_valid <= 1'b1;
`ifdef DFTTDO_PARITY_EN
                            par        <= ^cand;
`endif
                        end else begin
                            // Drop beats clear when both land on the same edge.
                            ovf_flag <= 1'b1;
                        end
                    end else begin
                        bcnt <= bcnt + CntW'(1);
                    end
                end
                StIdle: begin
                    bcnt <= '0;
                end
                default: begin
                    bcnt <= '0;
                end
            endcase
        end
    end

    assign bus.dout       = hold;
    assign bus.dout_valid = hold_valid;
    assign bus.ovf        = ovf_flag;
`ifdef DFTTDO_PARITY_EN
    assign bus.dout_par   = par;
`endif

    // Power pins and the shifted-out LSB carry no logic function.
    logic unused_bits;
    assign unused_bits = CELG ^ CELSUB ^ CELV ^ shreg[0];
endmodule

// File: tb/tb_dftprobe_tdo_deser.sv
// Bench for dftprobe_tdo_deser: directed vector table, reset/stream sequences, random vs model.
module tb_dftprobe_tdo_deser;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rstn;
    logic tdo_encore, ten_encore, clr;
    logic CELG, CELSUB, CELV;
    int   checks = 0;
    int   errors = 0;

    dftprobe_tdo_deser_if #(.WIDTH(W)) bus ();

    dftprobe_tdo_deser #(.WIDTH(W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .tdo_encore (tdo_encore),
        .ten_encore (ten_encore),
        .clr        (clr),
        .bus        (bus),
        .CELG       (CELG),
        .CELSUB     (CELSUB),
        .CELV       (CELV)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ten;
        logic       tdo;
        logic       rdy;
        logic       c;
        logic [7:0] edout;
        logic       evalid;
        logic       eovf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [7:0] d, input logic v,
                             input logic o);
        chk({name, " dout"}, 32'(bus.dout), 32'(d));
        chk({name, " valid"}, 32'(bus.dout_valid), 32'(v));
        chk({name, " ovf"}, 32'(bus.ovf), 32'(o));
`ifdef DFTTDO_PARITY_EN
        chk({name, " par"}, 32'(bus.dout_par), 32'(^d));
`endif
    endtask

    // Apply inputs, take one rising edge, and settle just after it.
    task automatic cyc(input logic ten, input logic tdo, input logic rdy, input logic c);
        ten_encore     = ten;
        tdo_encore     = tdo;
        bus.dout_ready = rdy;
        clr            = c;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic ten, input logic tdo, input logic rdy, input logic c,
                       input logic [7:0] d, input logic v, input logic o);
        vec_t r;
        r.ten = ten; r.tdo = tdo; r.rdy = rdy; r.c = c;
        r.edout = d; r.evalid = v; r.eovf = o;
        vecs.push_back(r);
    endtask

    // Streams bits lo..hi of word w (LSB first), all with the same expectation.
    task automatic add_bits(input logic [7:0] w, input int lo, input int hi, input logic rdy,
                            input logic [7:0] d, input logic v, input logic o);
        for (int i = lo; i <= hi; i++) add(1'b1, w[i], rdy, 1'b0, d, v, o);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #2;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Reference model state: collected bits and the handshake/overflow view.
    logic       mq[$];
    logic [7:0] m_dout;
    logic       m_valid, m_ovf;

    task automatic model_step(input logic ten, input logic tdo, input logic rdy, input logic c);
        logic       pre_valid;
        logic       drop;
        logic [7:0] w;
        pre_valid = m_valid;
        drop = 1'b0;
        if (pre_valid && rdy) m_valid = 1'b0;
        if (ten) begin
            mq.push_back(tdo);
            if (mq.size() == W) begin
                w = '0;
                for (int i = 0; i < int'(W); i++) w[i] = mq[i];
                mq.delete();
                if (!pre_valid || rdy) begin
                    m_dout  = w;
                    m_valid = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
        end else begin
            mq.delete();
        end
        if (drop) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
    endtask

    initial begin
        logic [7:0] words[8];
        logic       ten, tdo, rdy, c;

        CELG = 1'b0; CELSUB = 1'b0; CELV = 1'b1;
        ten_encore = 1'b0; tdo_encore = 1'b0; clr = 1'b0; bus.dout_ready = 1'b0;
        rstn = 1'b0;
        #1;
        check_out("reset", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        // Basic capture: bits 1,0,1,1,0,0,1,0 -> 0x4D, one-cycle valid pulse.
        add_bits(8'h4D, 0, 6, 1'b1, 8'h00, 1'b0, 1'b0);
        add_bits(8'h4D, 7, 7, 1'b1, 8'h4D, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 8'h4D, 1'b0, 1'b0);
        // Overflow: FF held, 00 dropped, then consume and clear.
        add_bits(8'hFF, 0, 6, 1'b0, 8'h4D, 1'b0, 1'b0);
        add_bits(8'hFF, 7, 7, 1'b0, 8'hFF, 1'b1, 1'b0);
        add_bits(8'h00, 0, 6, 1'b0, 8'hFF, 1'b1, 1'b0);
        add_bits(8'h00, 7, 7, 1'b0, 8'hFF, 1'b1, 1'b1);
        add(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        // Consume on the same edge the second word completes.
        add_bits(8'h3C, 0, 6, 1'b0, 8'hFF, 1'b0, 1'b0);
        add_bits(8'h3C, 7, 7, 1'b0, 8'h3C, 1'b1, 1'b0);
        add_bits(8'hA5, 0, 6, 1'b0, 8'h3C, 1'b1, 1'b0);
        add_bits(8'hA5, 7, 7, 1'b1, 8'hA5, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        // Enable drop after 5 bits realigns the word.
        add_bits(8'hFF, 0, 4, 1'b1, 8'hA5, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        add_bits(8'hAA, 0, 6, 1'b1, 8'hA5, 1'b0, 1'b0);
        add_bits(8'hAA, 7, 7, 1'b1, 8'hAA, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].ten, vecs[i].tdo, vecs[i].rdy, vecs[i].c);
            check_out($sformatf("vec%0d", i), vecs[i].edout, vecs[i].evalid, vecs[i].eovf);
        end

        // Async reset mid-word with a pending word and ovf set.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'(8'h5A >> i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check_out("pre_rst", 8'h5A, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        rstn = 1'b0;
        #2;
        check_out("async_rst", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'(8'hC3 >> i), 1'b1, 1'b0);
        check_out("post_rst7", 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        check_out("post_rst8", 8'hC3, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back stream: 64 bits, valid exactly every 8th edge.
        for (int k = 0; k < 8; k++) words[k] = 8'($urandom);
        for (int k = 0; k < 64; k++) begin
            cyc(1'b1, words[k / 8][k % 8], 1'b1, 1'b0);
            if (k % 8 == 7) begin
                check_out($sformatf("b2b_w%0d", k / 8), words[k / 8], 1'b1, 1'b0);
            end else begin
                chk($sformatf("b2b_gap%0d", k), 32'(bus.dout_valid), 32'd0);
            end
        end
        chk("b2b_ovf", 32'(bus.ovf), 32'd0);

        // Randomized run against the reference model.
        do_reset();
        mq.delete();
        m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            ten = ($urandom_range(0, 9) != 0);
            tdo = 1'($urandom);
            rdy = 1'($urandom_range(0, 2) != 0);
            c   = ($urandom_range(0, 19) == 0);
            model_step(ten, tdo, rdy, c);
            cyc(ten, tdo, rdy, c);
            check_out($sformatf("rnd%0d", n), m_dout, m_valid, m_ovf);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dftprobe_tdo_deser.md
# dftprobe_tdo_deser

Serial-to-parallel capture probe for the return path of a DFT scan channel: samples the core's `tdo_encore` bit stream while test enable is active, packs it into `WIDTH`-bit words, and presents each word to the service logic through a valid/ready handshake. It sits in the ATE service path opposite the TDI drive probe, so the service block can read back scan-out data that it shifted in through TDI.

## Interface
- `WIDTH`, default 8: captured word width in bits; legal range 2..32.
- `clk  input  1`: capture clock. All state changes on its rising edge.
- `rstn  input  1`: asynchronous, active-low reset. Sequential state is cleared on assertion and released synchronously to `clk`.
- `tdo_encore  input  1`: serial scan-out bit from the core.
- `ten_encore  input  1`: test enable. A bit is sampled only on cycles where this is 1.
- `clr  input  1`: synchronous clear of the sticky `ovf` flag.
- `dout  output  WIDTH`: captured word.
- `dout_valid  output  1`: `dout` holds an unconsumed word.
- `dout_ready  input  1`: consumer accepts `dout` when both `dout_valid` and `dout_ready` are 1.
- `ovf  output  1`: sticky flag. Set when a completed word was dropped.
- `dout_par  output  1`: even parity of `dout`. Present only with `DFTTDO_PARITY_EN`.
- `CELG`, `CELSUB`, `CELV  input  1`: ground, substrate and supply pins. They have no logic function.

## Operation
- **Internal state**
  - `shreg[WIDTH-1:0]`: shift register.
  - `bcnt`: bit counter, range 0..WIDTH-1, width clog2(WIDTH).
  - Holding register, which drives `dout`.
- **Bit order:** LSB first. Each sampled bit enters `shreg[WIDTH-1]` and `shreg` shifts right. The first bit sampled in a word ends up in `dout[0]`.
- **States:** IDLE (`ten_encore`=0) and SHIFT (`ten_encore`=1). There is no separate state register; `ten_encore` and `bcnt` define the state.
- **SHIFT, `bcnt` < WIDTH-1:** shift in `tdo_encore` and increment `bcnt`.
- **SHIFT, `bcnt` == WIDTH-1 (word complete):**
  - `bcnt` goes to 0.
  - Word candidate is `{tdo_encore, shreg[WIDTH-1:1]}`.
  - If the holding register is empty, or is being consumed this same cycle: load the candidate and set `dout_valid`=1.
  - Otherwise: keep the old word, drop the new one, and set `ovf`=1.
- **IDLE:**
  - `bcnt` goes to 0 and any partial word is discarded.
  - The holding register and `dout_valid` are unaffected.
- **Handshake:**
  - `dout_valid` falls on the edge where `dout_valid` and `dout_ready` are both 1, unless a new word loads on that same edge.
  - `dout` is stable while `dout_valid`=1 and not consumed.
- **`ovf`:**
  - `clr`=1 clears it.
  - If `clr` and a drop event occur in the same cycle, set wins and `ovf` stays 1.
- **Reset values:** `dout`=0, `dout_valid`=0, `ovf`=0, `dout_par`=0. Internally `shreg`=0 and `bcnt`=0.
- **Reset mid-word:** the partial word and any pending `dout` are lost. After release, capture restarts at bit 0.

## Timing
- `tdo_encore` is sampled on the rising edge of `clk` in any cycle with `ten_encore`=1.
- **Latency:**
  - `dout_valid` rises on the same edge that samples the last bit of a word, so it is visible in the next cycle.
  - Bit 0 to `dout_valid` spans WIDTH edges.
- **Throughput:** one word every WIDTH cycles with no gaps, provided the consumer asserts `dout_ready` at least once per word.
- **`ten_encore` drop:** dropping `ten_encore` for one cycle mid-word resets word alignment; the next sampled bit is bit 0.
- **Outputs:** all outputs are registered. There is no combinational path from `dout_ready` to any output.

## Configuration
- **`DFTTDO_PARITY_EN` defined:**
  - `dout_par` exists.
  - It is registered and loaded together with `dout` as `^candidate`, so it is 1 when the word has an odd number of ones.
  - Reset value 0.
- **Not defined:** the `dout_par` port and its parity logic are absent. All other behaviour is identical.

## Test plan
- **Basic capture.** `WIDTH`=8, `ten_encore`=1, `dout_ready`=1, serial bits 1,0,1,1,0,0,1,0 → `dout`=8'h4D, `dout_valid` high for exactly 1 cycle, `ovf`=0. With `DFTTDO_PARITY_EN`: `dout_par`=0.
- **Overflow with recovery.**
  - `dout_ready`=0 while 16 bits are streamed (8'hFF then 8'h00) → `dout`=8'hFF is retained and `ovf`=1.
  - Then `dout_ready`=1 → word consumed.
  - Then `clr`=1 → `ovf`=0.
- **Consume and complete on the same edge.** `dout_ready`=1 is asserted exactly on the edge where the second word 8'hA5 completes → `dout`=8'hA5, `dout_valid` stays 1, `ovf`=0.
- **Enable drop mid-word.**
  - `ten_encore`=1 for 5 bits, then 0 for 1 cycle.
  - Then 8 bits 0,1,0,1,0,1,0,1 → `dout`=8'hAA.
  - No word is produced from the 5-bit fragment.
- **Asynchronous reset mid-word.** `rstn` goes low after 3 bits with a valid word pending → `dout`=0, `dout_valid`=0 and `ovf`=0 immediately, with no `clk` edge needed. The next 8 bits form a fresh word.
- **Back-to-back stream.** 64 continuous bits with `dout_ready`=1 → 8 words in order, each `dout_valid` pulse spaced 8 cycles apart, `ovf`=0.
